// File: rtl/piradspi_pkg.sv
// Types and constants shared by the piradspi blocks that parse SPI engine responses.
package piradspi_pkg;

  localparam int MAGIC_WIDTH    = 8;
  localparam int CMD_ID_WIDTH   = 8;
  localparam int XFER_LEN_WIDTH = 16;

  localparam logic [MAGIC_WIDTH-1:0] RESPONSE_MAGIC = 8'hA5;

  typedef logic [XFER_LEN_WIDTH-1:0] xfer_len_t;
  typedef logic [CMD_ID_WIDTH-1:0]   cmd_id_t;

  typedef struct packed {
    logic id_mismatch;
    logic bad_magic;
  } parser_err_t;

  typedef struct packed {
    cmd_id_t   id;
    xfer_len_t xfer_len;
  } exp_entry_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_DATA,
    ST_DRAIN,
    ST_STATUS
  } parser_state_t;

endpackage

// File: rtl/piradspi_exp_queue.sv
// Expected-command FIFO: pointer+wrap-bit full/empty, registered not-full flag.
module piradspi_exp_queue
  import piradspi_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push_valid,
  output logic       push_ready,
  input  exp_entry_t push_data,
  input  logic       pop,
  output exp_entry_t head,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  exp_entry_t      mem [DEPTH];
  logic [AW:0]     wr_ptr;
  logic [AW:0]     rd_ptr;
  logic [AW:0]     wr_nxt;
  logic [AW:0]     rd_nxt;
  logic            do_push;
  logic            do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign do_push = push_valid && push_ready;
  assign do_pop  = pop && !empty;
  assign wr_nxt  = wr_ptr + PW'(do_push);
  assign rd_nxt  = rd_ptr + PW'(do_pop);
  assign head    = mem[rd_ptr[AW-1:0]];

  // push_ready is low in reset and reflects the post-update occupancy, so a
  // pop on a full queue only reopens the slot on the following cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      push_ready <= 1'b0;
    end else begin
      wr_ptr     <= wr_nxt;
      rd_ptr     <= rd_nxt;
      push_ready <= !((wr_nxt[AW] != rd_nxt[AW]) &&
                      (wr_nxt[AW-1:0] == rd_nxt[AW-1:0]));
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/piradspi_resp_parser.sv
// Checks SPI engine response headers against the expected-command stream,
// strips them, frames the data words with tlast and emits one status per command.
module piradspi_resp_parser
  import piradspi_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int XFER_LEN_WIDTH = piradspi_pkg::XFER_LEN_WIDTH,
  parameter int EXP_DEPTH      = 16,
  parameter int MAGIC_WIDTH    = piradspi_pkg::MAGIC_WIDTH,
  parameter int CMD_ID_WIDTH   = piradspi_pkg::CMD_ID_WIDTH
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 exp_tvalid,
  output logic                                 exp_tready,
  input  logic [CMD_ID_WIDTH+XFER_LEN_WIDTH-1:0] exp_tdata,
  input  logic                                 s_axis_tvalid,
  output logic                                 s_axis_tready,
  input  logic [DATA_WIDTH-1:0]                s_axis_tdata,
  output logic                                 m_axis_tvalid,
  input  logic                                 m_axis_tready,
  output logic [DATA_WIDTH-1:0]                m_axis_tdata,
  output logic                                 m_axis_tlast,
  output logic                                 sts_valid,
  output logic [CMD_ID_WIDTH-1:0]              sts_id,
  output logic [1:0]                           sts_err
);

  localparam int NW = XFER_LEN_WIDTH + 1;

  function automatic logic [NW-1:0] calc_nwords(input xfer_len_t len);
    logic [NW-1:0] sum;
    sum = {1'b0, len} + NW'(DATA_WIDTH - 1);
    return sum / NW'(DATA_WIDTH);
  endfunction

  parser_state_t      state;
  exp_entry_t         q_head;
  logic               q_empty;
  cmd_id_t            cur_id;
  logic [NW-1:0]      cur_nwords;
  logic [NW-1:0]      cnt;
  parser_err_t        err;
  logic [MAGIC_WIDTH-1:0]  hdr_magic;
  logic [CMD_ID_WIDTH-1:0] hdr_id;

  piradspi_exp_queue #(.DEPTH(EXP_DEPTH)) u_exp_queue (
    .clk        (clk),
    .rst        (rst),
    .push_valid (exp_tvalid),
    .push_ready (exp_tready),
    .push_data  (exp_tdata),
    .pop        (state == ST_IDLE),
    .head       (q_head),
    .empty      (q_empty)
  );

  assign hdr_magic = s_axis_tdata[DATA_WIDTH-1 -: MAGIC_WIDTH];
  assign hdr_id    = s_axis_tdata[DATA_WIDTH-MAGIC_WIDTH-1 -: CMD_ID_WIDTH];

  // Single output register: take a new word whenever the slot is empty or draining.
  assign s_axis_tready = (state == ST_HDR) ||
                         ((state == ST_DATA) && (m_axis_tready || !m_axis_tvalid));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      cur_id        <= '0;
      cur_nwords    <= '0;
      cnt           <= '0;
      err           <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tlast  <= 1'b0;
      sts_valid     <= 1'b0;
      sts_id        <= '0;
      sts_err       <= '0;
    end else begin
      sts_valid <= 1'b0;
      if (m_axis_tvalid && m_axis_tready) m_axis_tvalid <= 1'b0;

      unique case (state)
        ST_IDLE: begin
          if (!q_empty) begin
            cur_id     <= q_head.id;
            cur_nwords <= calc_nwords(q_head.xfer_len);
            state      <= ST_HDR;
          end
        end
        ST_HDR: begin
          if (s_axis_tvalid) begin
            err.bad_magic   <= (hdr_magic != RESPONSE_MAGIC);
            err.id_mismatch <= (hdr_id != cur_id);
            cnt             <= cur_nwords;
            state           <= (cur_nwords == '0) ? ST_STATUS : ST_DATA;
          end
        end
        ST_DATA: begin
          if (s_axis_tvalid && s_axis_tready) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= s_axis_tdata;
            m_axis_tlast  <= (cnt == NW'(1));
            cnt           <= cnt - NW'(1);
            if (cnt == NW'(1)) state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          // Status must never overtake the final data beat.
          if (m_axis_tvalid && m_axis_tready) state <= ST_STATUS;
        end
        ST_STATUS: begin
          sts_valid <= 1'b1;
          sts_id    <= cur_id;
          sts_err   <= err;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_piradspi_resp_parser.sv
// Directed bench for piradspi_resp_parser with immediate-assertion checks.
module tb_piradspi_resp_parser;
  import piradspi_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        exp_tvalid = 1'b0;
  logic        exp_tready;
  logic [23:0] exp_tdata = '0;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tready;
  logic [31:0] s_axis_tdata = '0;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tlast;
  logic        sts_valid;
  logic [7:0]  sts_id;
  logic [1:0]  sts_err;

  piradspi_resp_parser #(
    .DATA_WIDTH(32), .XFER_LEN_WIDTH(16), .EXP_DEPTH(16),
    .MAGIC_WIDTH(8), .CMD_ID_WIDTH(8)
  ) dut (
    .clk(clk), .rst(rst),
    .exp_tvalid(exp_tvalid), .exp_tready(exp_tready), .exp_tdata(exp_tdata),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready), .s_axis_tdata(s_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast),
    .sts_valid(sts_valid), .sts_id(sts_id), .sts_err(sts_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int tmode = 0;

  typedef struct { logic [31:0] dat; logic last; int cyc; } beat_t;
  typedef struct { logic [7:0] id; logic [1:0] err; int cyc; } sts_rec_t;
  beat_t    beats[$];
  sts_rec_t stss[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] hdr(input logic [7:0] m, input logic [7:0] id);
    return {m, id, 16'hBEEF};
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Sink ready: constant 1, or the repeating 1,0,0,1 pattern.
  initial begin
    int ph = 0;
    m_axis_tready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (tmode == 1) begin
        m_axis_tready = (ph == 0) || (ph == 3);
        ph = (ph + 1) % 4;
      end else begin
        m_axis_tready = 1'b1;
      end
    end
  end

  // Output monitor: records handshaken beats and status pulses, checks hold-while-stalled.
  logic        prev_stall = 1'b0;
  logic [31:0] prev_dat = '0;
  logic        prev_last = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall)
        chk("stall_hold", {m_axis_tvalid, m_axis_tlast, m_axis_tdata}, {1'b1, prev_last, prev_dat});
      if (m_axis_tvalid && m_axis_tready) beats.push_back('{m_axis_tdata, m_axis_tlast, cyc});
      if (sts_valid) stss.push_back('{sts_id, sts_err, cyc});
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_dat   = m_axis_tdata;
      prev_last  = m_axis_tlast;
    end
  end

  task automatic push_exp(input logic [7:0] id, input logic [15:0] len);
    int n = 0;
    exp_tvalid = 1'b1;
    exp_tdata  = {id, len};
    @(negedge clk);
    while (!exp_tready && n < 100) begin @(negedge clk); n++; end
    chk("push_timeout", 64'(n >= 100), 64'd0);
    @(posedge clk); #1;
    exp_tvalid = 1'b0;
  endtask

  // Leaves tvalid high so consecutive calls stream back to back.
  task automatic send_word(input logic [31:0] d);
    int n = 0;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = d;
    @(negedge clk);
    while (!s_axis_tready && n < 200) begin @(negedge clk); n++; end
    chk("send_timeout", 64'(n >= 200), 64'd0);
    @(posedge clk); #1;
  endtask

  task automatic wait_sts(input int want);
    int n = 0;
    while (stss.size() < want && n < 500) begin @(posedge clk); #2; n++; end
    chk("sts_timeout", 64'(n >= 500), 64'd0);
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state (checked mid-reset, before and after the first clock edge).
    #3;
    chk("rst_exp_tready", exp_tready, 0);
    chk("rst_s_tready", s_axis_tready, 0);
    #10;
    chk("rst_m_tvalid", m_axis_tvalid, 0);
    chk("rst_m_tlast", m_axis_tlast, 0);
    chk("rst_sts_valid", sts_valid, 0);
    chk("rst_sts_id", sts_id, 0);
    chk("rst_sts_err", sts_err, 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // Single-word command.
    beats.delete(); stss.delete();
    push_exp(8'h05, 16'd8);
    send_word(hdr(RESPONSE_MAGIC, 8'h05));
    send_word(32'hDEADBEEF);
    s_axis_tvalid = 1'b0;
    wait_sts(1);
    chk("t1_nbeats", beats.size(), 1);
    chk("t1_dat", beats[0].dat, 32'hDEADBEEF);
    chk("t1_last", beats[0].last, 1);
    chk("t1_sts_id", stss[0].id, 8'h05);
    chk("t1_sts_err", stss[0].err, 2'b00);

    // Three words with a toggling sink.
    beats.delete(); stss.delete();
    tmode = 1;
    push_exp(8'h11, 16'd96);
    send_word(hdr(RESPONSE_MAGIC, 8'h11));
    send_word(32'hA000_0001);
    send_word(32'hA000_0002);
    send_word(32'hA000_0003);
    s_axis_tvalid = 1'b0;
    wait_sts(1);
    tmode = 0;
    chk("t2_nbeats", beats.size(), 3);
    chk("t2_dat0", beats[0].dat, 32'hA000_0001);
    chk("t2_dat1", beats[1].dat, 32'hA000_0002);
    chk("t2_dat2", beats[2].dat, 32'hA000_0003);
    chk("t2_last", {beats[0].last, beats[1].last, beats[2].last}, 3'b001);
    chk("t2_sts_after_last", 64'(stss[0].cyc > beats[2].cyc), 1);
    chk("t2_sts_id", stss[0].id, 8'h11);
    chk("t2_sts_err", stss[0].err, 2'b00);

    // Zero-length command: header only.
    beats.delete(); stss.delete();
    push_exp(8'h22, 16'd0);
    send_word(hdr(RESPONSE_MAGIC, 8'h22));
    s_axis_tvalid = 1'b0;
    wait_sts(1);
    chk("t3_nbeats", beats.size(), 0);
    chk("t3_sts_id", stss[0].id, 8'h22);
    chk("t3_sts_err", stss[0].err, 2'b00);

    // Bad magic and wrong ID: data still framed, both error bits set.
    beats.delete(); stss.delete();
    push_exp(8'h33, 16'd32);
    send_word(hdr(8'h5A, 8'h34));
    send_word(32'h1234_5678);
    s_axis_tvalid = 1'b0;
    wait_sts(1);
    chk("t4_nbeats", beats.size(), 1);
    chk("t4_dat", beats[0].dat, 32'h1234_5678);
    chk("t4_last", beats[0].last, 1);
    chk("t4_sts_id", stss[0].id, 8'h33);
    chk("t4_sts_err", stss[0].err, 2'b11);

    // Fill the queue: the first entry is popped into the parser at once, so
    // 17 pushes leave 16 queued and exp_tready low.
    beats.delete(); stss.delete();
    for (int i = 0; i < 17; i++)
      push_exp(8'h40 + 8'(i), (i % 2 == 1) ? 16'd64 : 16'd33);
    @(negedge clk);
    chk("t5_full", exp_tready, 0);
    exp_tvalid = 1'b1;
    exp_tdata  = {8'h99, 16'd32};
    repeat (3) @(negedge clk);
    chk("t5_full_held", exp_tready, 0);
    @(posedge clk); #1;
    exp_tvalid = 1'b0;
    for (int i = 0; i < 17; i++) begin
      send_word(hdr(RESPONSE_MAGIC, 8'h40 + 8'(i)));
      send_word({16'hB000, 8'(i), 8'h00});
      send_word({16'hB000, 8'(i), 8'h01});
    end
    s_axis_tvalid = 1'b0;
    wait_sts(17);
    repeat (10) @(posedge clk);
    #2;
    chk("t5_nsts", stss.size(), 17);
    chk("t5_nbeats", beats.size(), 34);
    for (int i = 0; i < 17; i++) begin
      chk("t5_sts_id", stss[i].id, 8'h40 + 8'(i));
      chk("t5_sts_err", stss[i].err, 2'b00);
      chk("t5_dat0", beats[2*i].dat, {16'hB000, 8'(i), 8'h00});
      chk("t5_dat1", beats[2*i+1].dat, {16'hB000, 8'(i), 8'h01});
      chk("t5_last", {beats[2*i].last, beats[2*i+1].last}, 2'b01);
      chk("t5_b2b", beats[2*i+1].cyc - beats[2*i].cyc, 1);
    end

    // Reset in the middle of a 4-word packet with another entry still queued.
    push_exp(8'h77, 16'd128);
    push_exp(8'h78, 16'd32);
    send_word(hdr(RESPONSE_MAGIC, 8'h77));
    send_word(32'hC000_0000);
    send_word(32'hC000_0001);
    s_axis_tvalid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("t6_async_m_tvalid", m_axis_tvalid, 0);
    chk("t6_async_m_tlast", m_axis_tlast, 0);
    chk("t6_async_s_tready", s_axis_tready, 0);
    chk("t6_async_exp_tready", exp_tready, 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    beats.delete(); stss.delete();
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = hdr(RESPONSE_MAGIC, 8'h78);
    repeat (5) @(negedge clk);
    chk("t6_queue_empty", s_axis_tready, 0);
    chk("t6_exp_tready", exp_tready, 1);
    @(posedge clk); #1;
    s_axis_tvalid = 1'b0;
    push_exp(8'h79, 16'd32);
    send_word(hdr(RESPONSE_MAGIC, 8'h79));
    send_word(32'hCAFE_F00D);
    s_axis_tvalid = 1'b0;
    wait_sts(1);
    chk("t6_nbeats", beats.size(), 1);
    chk("t6_dat", beats[0].dat, 32'hCAFE_F00D);
    chk("t6_last", beats[0].last, 1);
    chk("t6_sts_id", stss[0].id, 8'h79);
    chk("t6_sts_err", stss[0].err, 2'b00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
